// File: rtl/alu_unit.sv
// ---------------------------------------------------------------------------
// alu_unit -- integer execute stage for the out-of-order core.
//
// Takes one issued RV32I instruction per cycle from the reservation station.
// The operands arrive fully resolved. The unit computes the rd write value,
// the resolved next PC and the redirect flag, and registers them onto the ALU
// CDB port. The RS, LSB and ROB all read this port.
//
// There is one registered stage, so latency is one cycle and throughput is
// one instruction per cycle. There is no backpressure.
//
// Priority on each clock edge, highest first:
//   rst low (async)   : every output register cleared
//   rollback_from_rob : every output register cleared, incoming op dropped
//   rdy low           : every register holds
//   otherwise         : capture the incoming op, or a bubble
//
// Optional feature macro: ALU_MUL_EN
//   Defined   -> MUL/MULH/MULHSU/MULHU decoded, with the same 1-cycle latency.
//   Undefined -> those opcodes take the unknown-opcode path and no multiplier
//                logic is built.
//
// Ports:
//   clk                in   clock, rising edge
//   rst                in   asynchronous reset, active low
//   rdy                in   global ready; low freezes all state
//   rollback_from_rob  in   flush request
//   valid_from_rs      in   issued instruction valid
//   inst_type_from_rs  in   [OPT_W]   opcode (shared opcode header encoding)
//   alias_from_rs      in   [ALIAS_W] destination ROB alias
//   Vi_from_rs         in   [XLEN]    rs1 value
//   Vj_from_rs         in   [XLEN]    rs2 value
//   imm_from_rs        in   [XLEN]    sign-extended immediate
//   pc_from_rs         in   [XLEN]    instruction PC
//   valid_to_cdb       out  result valid
//   alias_to_cdb       out  [ALIAS_W] result alias
//   result_to_cdb      out  [XLEN]    rd write value
//   jump_to_rob        out  control-flow redirect taken
//   target_to_rob      out  [XLEN]    resolved next PC
// ---------------------------------------------------------------------------
module alu_unit #(
    parameter int XLEN    = 32,
    parameter int ALIAS_W = 4,
    parameter int OPT_W   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               rollback_from_rob,
    input  logic               valid_from_rs,
    input  logic [OPT_W-1:0]   inst_type_from_rs,
    input  logic [ALIAS_W-1:0] alias_from_rs,
    input  logic [XLEN-1:0]    Vi_from_rs,
    input  logic [XLEN-1:0]    Vj_from_rs,
    input  logic [XLEN-1:0]    imm_from_rs,
    input  logic [XLEN-1:0]    pc_from_rs,
    output logic               valid_to_cdb,
    output logic [ALIAS_W-1:0] alias_to_cdb,
    output logic [XLEN-1:0]    result_to_cdb,
    output logic               jump_to_rob,
    output logic [XLEN-1:0]    target_to_rob
);

    localparam int SH_W = $clog2(XLEN);

    // Shared opcode header encoding. Loads and stores (11..18) belong to the
    // LSB, so this unit treats them as unknown.
    localparam logic [OPT_W-1:0] OP_LUI    = OPT_W'(1);
    localparam logic [OPT_W-1:0] OP_AUIPC  = OPT_W'(2);
    localparam logic [OPT_W-1:0] OP_JAL    = OPT_W'(3);
    localparam logic [OPT_W-1:0] OP_JALR   = OPT_W'(4);
    localparam logic [OPT_W-1:0] OP_BEQ    = OPT_W'(5);
    localparam logic [OPT_W-1:0] OP_BNE    = OPT_W'(6);
    localparam logic [OPT_W-1:0] OP_BLT    = OPT_W'(7);
    localparam logic [OPT_W-1:0] OP_BGE    = OPT_W'(8);
    localparam logic [OPT_W-1:0] OP_BLTU   = OPT_W'(9);
    localparam logic [OPT_W-1:0] OP_BGEU   = OPT_W'(10);
    localparam logic [OPT_W-1:0] OP_ADDI   = OPT_W'(19);
    localparam logic [OPT_W-1:0] OP_SLTI   = OPT_W'(20);
    localparam logic [OPT_W-1:0] OP_SLTIU  = OPT_W'(21);
    localparam logic [OPT_W-1:0] OP_XORI   = OPT_W'(22);
    localparam logic [OPT_W-1:0] OP_ORI    = OPT_W'(23);
    localparam logic [OPT_W-1:0] OP_ANDI   = OPT_W'(24);
    localparam logic [OPT_W-1:0] OP_SLLI   = OPT_W'(25);
    localparam logic [OPT_W-1:0] OP_SRLI   = OPT_W'(26);
    localparam logic [OPT_W-1:0] OP_SRAI   = OPT_W'(27);
    localparam logic [OPT_W-1:0] OP_ADD    = OPT_W'(28);
    localparam logic [OPT_W-1:0] OP_SUB    = OPT_W'(29);
    localparam logic [OPT_W-1:0] OP_SLL    = OPT_W'(30);
    localparam logic [OPT_W-1:0] OP_SLT    = OPT_W'(31);
    localparam logic [OPT_W-1:0] OP_SLTU   = OPT_W'(32);
    localparam logic [OPT_W-1:0] OP_XOR    = OPT_W'(33);
    localparam logic [OPT_W-1:0] OP_SRL    = OPT_W'(34);
    localparam logic [OPT_W-1:0] OP_SRA    = OPT_W'(35);
    localparam logic [OPT_W-1:0] OP_OR     = OPT_W'(36);
    localparam logic [OPT_W-1:0] OP_AND    = OPT_W'(37);
`ifdef ALU_MUL_EN
    localparam logic [OPT_W-1:0] OP_MUL    = OPT_W'(38);
    localparam logic [OPT_W-1:0] OP_MULH   = OPT_W'(39);
    localparam logic [OPT_W-1:0] OP_MULHSU = OPT_W'(40);
    localparam logic [OPT_W-1:0] OP_MULHU  = OPT_W'(41);
`endif

    // Returns 1 when the comparison a < b holds, as a full-width 0/1 result.
    function automatic logic [XLEN-1:0] set_less(input logic lt);
        return {{(XLEN-1){1'b0}}, lt};
    endfunction

    // Arithmetic right shift on an explicitly signed operand.
    function automatic logic [XLEN-1:0] shift_ra(input logic signed [XLEN-1:0] a,
                                                 input logic [SH_W-1:0] sh);
        return XLEN'(a >>> sh);
    endfunction

    // ------------------------------------------------------------------
    // Stage p0: decode and execute (combinational)
    // ------------------------------------------------------------------
    logic signed [XLEN-1:0] w_vi_s;
    logic signed [XLEN-1:0] w_vj_s;
    logic signed [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0]        w_pc4;
    logic [XLEN-1:0]        w_pc_imm;
    logic [XLEN-1:0]        w_jalr_tgt;
    logic [SH_W-1:0]        w_sh_r;
    logic [SH_W-1:0]        w_sh_i;
    logic                   w_eq;
    logic                   w_lt_s;
    logic                   w_lt_u;
    logic                   w_br_cond;
    logic                   w_is_branch;
    logic [XLEN-1:0]        w_result_p0;
    logic [XLEN-1:0]        w_target_p0;
    logic                   w_jump_p0;

    assign w_vi_s     = signed'(Vi_from_rs);
    assign w_vj_s     = signed'(Vj_from_rs);
    assign w_imm_s    = signed'(imm_from_rs);
    assign w_pc4      = pc_from_rs + XLEN'(4);
    assign w_pc_imm   = pc_from_rs + imm_from_rs;
    assign w_jalr_tgt = (Vi_from_rs + imm_from_rs) & ~XLEN'(1);
    assign w_sh_r     = Vj_from_rs[SH_W-1:0];
    assign w_sh_i     = imm_from_rs[SH_W-1:0];
    assign w_eq       = (Vi_from_rs == Vj_from_rs);
    assign w_lt_s     = (w_vi_s < w_vj_s);
    assign w_lt_u     = (Vi_from_rs < Vj_from_rs);

`ifdef ALU_MUL_EN
    // One 2*XLEN multiplier covers all four forms. Each operand is sign- or
    // zero-extended to 2*XLEN. The true product always fits in 2*XLEN
    // two's complement, so the wrapped product is exact in every case.
    logic                   w_mul_a_sgn;
    logic                   w_mul_b_sgn;
    logic [2*XLEN-1:0]      w_mul_a;
    logic [2*XLEN-1:0]      w_mul_b;
    logic [2*XLEN-1:0]      w_mul_prod;

    assign w_mul_a_sgn = (inst_type_from_rs == OP_MULH) || (inst_type_from_rs == OP_MULHSU);
    assign w_mul_b_sgn = (inst_type_from_rs == OP_MULH);
    assign w_mul_a     = {{XLEN{w_mul_a_sgn & Vi_from_rs[XLEN-1]}}, Vi_from_rs};
    assign w_mul_b     = {{XLEN{w_mul_b_sgn & Vj_from_rs[XLEN-1]}}, Vj_from_rs};
    assign w_mul_prod  = w_mul_a * w_mul_b;
`endif

    always_comb begin
        w_is_branch = 1'b0;
        w_br_cond   = 1'b0;
        case (inst_type_from_rs)
            OP_BEQ:  begin w_is_branch = 1'b1; w_br_cond = w_eq;    end
            OP_BNE:  begin w_is_branch = 1'b1; w_br_cond = !w_eq;   end
            OP_BLT:  begin w_is_branch = 1'b1; w_br_cond = w_lt_s;  end
            OP_BGE:  begin w_is_branch = 1'b1; w_br_cond = !w_lt_s; end
            OP_BLTU: begin w_is_branch = 1'b1; w_br_cond = w_lt_u;  end
            OP_BGEU: begin w_is_branch = 1'b1; w_br_cond = !w_lt_u; end
            default: begin w_is_branch = 1'b0; w_br_cond = 1'b0;    end
        endcase
    end

    always_comb begin
        // Default is fall-through with result 0. This also covers unknown
        // opcodes, so an unknown op still retires cleanly.
        w_result_p0 = '0;
        w_target_p0 = w_pc4;
        w_jump_p0   = 1'b0;
        case (inst_type_from_rs)
            OP_LUI:    w_result_p0 = imm_from_rs;
            OP_AUIPC:  w_result_p0 = w_pc_imm;
            OP_JAL: begin
                w_result_p0 = w_pc4;
                w_target_p0 = w_pc_imm;
                w_jump_p0   = 1'b1;
            end
            OP_JALR: begin
                w_result_p0 = w_pc4;
                w_target_p0 = w_jalr_tgt;
                w_jump_p0   = 1'b1;
            end
            OP_ADDI:   w_result_p0 = Vi_from_rs + imm_from_rs;
            OP_SLTI:   w_result_p0 = set_less(w_vi_s < w_imm_s);
            OP_SLTIU:  w_result_p0 = set_less(Vi_from_rs < imm_from_rs);
            OP_XORI:   w_result_p0 = Vi_from_rs ^ imm_from_rs;
            OP_ORI:    w_result_p0 = Vi_from_rs | imm_from_rs;
            OP_ANDI:   w_result_p0 = Vi_from_rs & imm_from_rs;
            OP_SLLI:   w_result_p0 = Vi_from_rs << w_sh_i;
            OP_SRLI:   w_result_p0 = Vi_from_rs >> w_sh_i;
            OP_SRAI:   w_result_p0 = shift_ra(w_vi_s, w_sh_i);
            OP_ADD:    w_result_p0 = Vi_from_rs + Vj_from_rs;
            OP_SUB:    w_result_p0 = Vi_from_rs - Vj_from_rs;
            OP_SLL:    w_result_p0 = Vi_from_rs << w_sh_r;
            OP_SLT:    w_result_p0 = set_less(w_lt_s);
            OP_SLTU:   w_result_p0 = set_less(w_lt_u);
            OP_XOR:    w_result_p0 = Vi_from_rs ^ Vj_from_rs;
            OP_SRL:    w_result_p0 = Vi_from_rs >> w_sh_r;
            OP_SRA:    w_result_p0 = shift_ra(w_vi_s, w_sh_r);
            OP_OR:     w_result_p0 = Vi_from_rs | Vj_from_rs;
            OP_AND:    w_result_p0 = Vi_from_rs & Vj_from_rs;
`ifdef ALU_MUL_EN
            OP_MUL:    w_result_p0 = w_mul_prod[XLEN-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  w_result_p0 = w_mul_prod[2*XLEN-1:XLEN];
`endif
            default: begin
                // Branches share this path. Their result stays 0, and the
                // jump/target come from the condition.
                if (w_is_branch) begin
                    w_jump_p0   = w_br_cond;
                    w_target_p0 = w_br_cond ? w_pc_imm : w_pc4;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stage p1: CDB output registers
    // ------------------------------------------------------------------
    logic               r_valid_p1;
    logic [ALIAS_W-1:0] r_alias_p1;
    logic [XLEN-1:0]    r_result_p1;
    logic               r_jump_p1;
    logic [XLEN-1:0]    r_target_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid_p1  <= 1'b0;
            r_alias_p1  <= '0;
            r_result_p1 <= '0;
            r_jump_p1   <= 1'b0;
            r_target_p1 <= '0;
        end else if (rollback_from_rob) begin
            r_valid_p1  <= 1'b0;
            r_alias_p1  <= '0;
            r_result_p1 <= '0;
            r_jump_p1   <= 1'b0;
            r_target_p1 <= '0;
        end else if (rdy) begin
            if (valid_from_rs) begin
                r_valid_p1  <= 1'b1;
                r_alias_p1  <= alias_from_rs;
                r_result_p1 <= w_result_p0;
                r_jump_p1   <= w_jump_p0;
                r_target_p1 <= w_target_p0;
            end else begin
                // Bubble: clear the control fields only. Result and target
                // are don't-care while valid is low, so they hold.
                r_valid_p1  <= 1'b0;
                r_alias_p1  <= '0;
                r_jump_p1   <= 1'b0;
            end
        end
    end

    assign valid_to_cdb  = r_valid_p1;
    assign alias_to_cdb  = r_alias_p1;
    assign result_to_cdb = r_result_p1;
    assign jump_to_rob   = r_jump_p1;
    assign target_to_rob = r_target_p1;

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- Integer execute stage directly downstream of the reservation station.
- Consumes one issued RV32I instruction per cycle (operands fully resolved) and computes the result, next-PC and branch outcome.
- Broadcasts on the ALU CDB port read by the RS, LSB and ROB.
- Registered single-stage pipeline with rollback flush and rdy stall.

Parameters:
- XLEN, 32, datapath width
- ALIAS_W, 4, ROB alias width (matches ROB_RANGE)
- OPT_W, 6, inst_type width (matches OPT_RANGE)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global ready; low = freeze all state
- rollback_from_rob  in  1  flush, synchronous
- valid_from_rs  in  1  issued instruction valid
- inst_type_from_rs  in  OPT_W  opcode, shared opcode header encoding
- alias_from_rs  in  ALIAS_W  destination ROB alias
- Vi_from_rs  in  XLEN  rs1 value
- Vj_from_rs  in  XLEN  rs2 value
- imm_from_rs  in  XLEN  sign-extended immediate
- pc_from_rs  in  XLEN  instruction PC
- valid_to_cdb  out  1  result valid
- alias_to_cdb  out  ALIAS_W  result alias
- result_to_cdb  out  XLEN  rd write value
- jump_to_rob  out  1  control-flow redirect taken
- target_to_rob  out  XLEN  resolved next PC

Behaviour:
- Reset (rst low, async): all outputs are 0. Reset takes priority over everything.
- Priority on each clk edge, highest first: rollback_from_rob=1, then rdy=0, then normal capture.
  - rollback_from_rob=1: valid_to_cdb<=0, jump_to_rob<=0, other outputs<=0. Any input arriving that same edge is dropped.
  - rdy=0: no register changes. Outputs hold, so valid_to_cdb can stay high across stall cycles; consumers also freeze.
  - Normal: latency exactly 1 cycle. Inputs at edge N appear on outputs after edge N. Throughput is 1 per cycle, with no backpressure.
  - valid_from_rs=0 at an edge: valid_to_cdb<=0, jump_to_rob<=0, alias_to_cdb<=0. result_to_cdb and target_to_rob may hold.
- Arithmetic is 32-bit with wrap-around; no overflow flags.
  - ADD/ADDI = Vi+Vj / Vi+imm. SUB = Vi-Vj.
  - Shifts use amount [4:0] of Vj (R-type) or imm (I-type). SRA/SRAI are arithmetic.
  - SLT/SLTI are signed; SLTU/SLTIU are unsigned; result is 0 or 1.
  - AND/OR/XOR and their immediate forms are bitwise.
  - LUI: result=imm. AUIPC: result=pc+imm.
- Control flow:
  - Non-control ops: target_to_rob=pc+4, jump_to_rob=0.
  - JAL: result=pc+4, target=pc+imm, jump=1.
  - JALR: result=pc+4, target=(Vi+imm)&~1, jump=1.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: result=0. cond compares Vi vs Vj (signed for BLT/BGE, unsigned for the U forms). jump=cond. target = cond ? pc+imm : pc+4.
- Unknown or unsupported opcode with valid=1: valid_to_cdb=1, result=0, jump=0, target=pc+4. Never hangs.
- Alias 0 is reserved as "no dependency". An input with alias 0 is still executed, and its output carries alias 0.
- Same-cycle events: a new instruction can be captured on the edge immediately following a broadcast. Back-to-back results are driven on consecutive cycles.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: MUL, MULH, MULHSU, MULHU are decoded with the same 1-cycle latency.
  - MUL = low 32 bits of the product.
  - MULH = high 32 bits, signed×signed.
  - MULHSU = high 32 bits, signed Vi × unsigned Vj.
  - MULHU = high 32 bits, unsigned×unsigned.
- Not defined: these opcodes take the unknown-opcode path (result 0, jump 0). No multiplier logic is synthesized.

Test Plan:
- Reset/idle: hold rst low, then release. All outputs are 0 and stay 0 with valid_from_rs=0.
- ADD then SUB back-to-back:
  - Cycle 1: Vi=7, Vj=0xFFFFFFFF, alias 3.
  - Cycle 2: SUB Vi=0, Vj=1, alias 4.
  - Required: valid on 2 consecutive cycles. Alias 3 → result 6. Alias 4 → result 0xFFFFFFFF. jump 0. Each target = its pc+4.
- Branch/jump:
  - BLT Vi=0xFFFFFFFE, Vj=1, pc=0x100, imm=0x20 → jump 1, target 0x120.
  - BLTU with the same operands → jump 0, target 0x104.
  - JALR Vi=0x201, imm=2, pc=0x40 → result 0x44, target 0x202, jump 1.
- Shifts/compare:
  - SRA Vi=0x80000000, Vj=0x24 → 0xF8000000 (amount 4).
  - SLTIU Vi=1, imm=0xFFFFFFFF → 1.
- Rollback: instruction valid at edge N with rollback_from_rob=1 at edge N → valid_to_cdb 0 after edge N. The next instruction at N+1 executes normally.
- Stall: valid ADDI captured, then rdy low for 3 cycles with inputs changing → outputs frozen with valid_to_cdb=1. rdy high → next captured instruction appears one cycle later. With ALU_MUL_EN: MULH Vi=0x80000000, Vj=2 → 0xFFFFFFFF.
